// File: rtl/anim_frame_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : anim_frame_seq_pkg
//  Brief   : Shared state encodings and default sizing for the LED animation
//            frame sequencer and the digit pattern decoders.
//  Revision: 1.0  initial release
// ============================================================================
package anim_frame_seq_pkg;

    // Sequencer states; 2-bit encoding shared with anything that observes the FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } anim_state_t;

    // Frame index width is fixed by the decoder input width
    localparam int IDX_W_DEF      = 5;
    // clk cycles per frame at speed=0
    localparam int DIV_BASE_DEF   = 25_000_000;
    // Last frame of the default animation
    localparam int FRAME_LAST_DEF = 14;

endpackage : anim_frame_seq_pkg
`default_nettype wire

// File: rtl/anim_frame_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : anim_frame_seq_if
//  Brief   : Control/status bundle between the animation controller (master)
//            and the frame sequencer (slave).
//  Revision: 1.0  initial release
// ============================================================================
interface anim_frame_seq_if #(
    parameter int IDX_W = 5
);
    logic             start;       // 1-cycle pulse: (re)start playback
    logic             pause;       // level: freeze playback
    logic             loop_en;     // 1 = loop, 0 = one-shot
    logic             dir;         // 0 = forward, 1 = reverse
    logic [1:0]       speed;       // frame period = DIV_BASE >> speed
    logic [IDX_W-1:0] frame_idx;   // current frame
    logic             frame_tick;  // pulse on each frame change
    logic             busy;        // RUN or PAUSE
    logic             done;        // one-shot finished

    modport master (
        output start, pause, loop_en, dir, speed,
        input  frame_idx, frame_tick, busy, done
    );

    modport slave (
        input  start, pause, loop_en, dir, speed,
        output frame_idx, frame_tick, busy, done
    );
endinterface : anim_frame_seq_if
`default_nettype wire

// File: rtl/anim_frame_seq_prescaler.sv
`default_nettype none
// ============================================================================
//  Module  : anim_frame_seq_prescaler
//  Brief   : Frame-rate prescaler. Counts 0..T-1 with T = DIV_BASE >> speed
//            and pulses tc at the terminal count. A count already at or past
//            the new terminal value after a speed change terminates at once.
//  Revision: 1.0  initial release
// ============================================================================
module anim_frame_seq_prescaler #(
    parameter int DIV_BASE = 25_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       clr_i,
    input  wire logic       en_i,
    input  wire logic [1:0] speed_i,
    output logic            tc_o
);
    localparam int CNT_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      last_cnt;
    logic             at_term;

    // Terminal value follows speed every cycle; >= gives the clamp on speed-up
    always_comb begin
        last_cnt = (32'(DIV_BASE) >> speed_i) - 32'd1;
        at_term  = ({{(32-CNT_W){1'b0}}, cnt_q} >= last_cnt);
        tc_o     = en_i & ~clr_i & at_term;
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_term ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register; holds its value whenever counting is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : anim_frame_seq_prescaler
`default_nettype wire

// File: rtl/anim_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module  : anim_frame_seq
//  Brief   : Frame sequencer for the LED animation path. Start/pause,
//            one-shot or looped play, forward/reverse order, 4 speeds.
//            Build option ANIM_PINGPONG_EN: looped play bounces between the
//            end frames instead of wrapping.
//  Revision: 1.0  initial release
// ============================================================================
module anim_frame_seq
    import anim_frame_seq_pkg::*;
#(
    parameter int DIV_BASE   = DIV_BASE_DEF,
    parameter int FRAME_LAST = FRAME_LAST_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    anim_frame_seq_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LAST);

    anim_state_t      state_q;
    logic [IDX_W-1:0] idx_q;
    logic             dir_q;
    logic             tick_q;
    logic             busy_q;
    logic             done_q;

    logic             active;
    logic             presc_en;
    logic             tc;
    logic             at_end;
    logic [IDX_W-1:0] idx_fwd;
    logic [IDX_W-1:0] idx_rev;

    // Prescaler advances in RUN, and on the cycle PAUSE releases, so a pause
    // costs exactly the cycles pause was high
    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        presc_en = active & ~bus.pause;
        at_end   = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);
        idx_fwd  = idx_q + 1'b1;
        idx_rev  = idx_q - 1'b1;
    end

    anim_frame_seq_prescaler #(
        .DIV_BASE (DIV_BASE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.start),
        .en_i    (presc_en),
        .speed_i (bus.speed),
        .tc_o    (tc)
    );

    // Playback FSM with registered outputs; start overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (bus.start) begin
                idx_q   <= bus.dir ? LAST_IDX : '0;
                dir_q   <= bus.dir;
                state_q <= bus.pause ? ST_PAUSE : ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (active) begin
                if (bus.pause) begin
                    state_q <= ST_PAUSE;
                end else begin
                    state_q <= ST_RUN;
                    if (tc) begin
                        if (!at_end) begin
                            idx_q  <= dir_q ? idx_rev : idx_fwd;
                            tick_q <= 1'b1;
                        end else if (bus.loop_en) begin
                            tick_q <= 1'b1;
`ifdef ANIM_PINGPONG_EN
                            // Bounce: step away from the end frame just shown
                            dir_q  <= ~dir_q;
                            idx_q  <= dir_q ? idx_fwd : idx_rev;
`else
                            idx_q  <= dir_q ? LAST_IDX : '0;
`endif
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.frame_idx  = idx_q;
    assign bus.frame_tick = tick_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule : anim_frame_seq
`default_nettype wire

// File: tb/tb_anim_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_anim_frame_seq
//  Brief   : Directed self-checking bench for anim_frame_seq with
//            DIV_BASE=8, FRAME_LAST=3.
//  Revision: 1.0  initial release
// ============================================================================
module tb_anim_frame_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    anim_frame_seq_if #(.IDX_W(5)) bus ();

    anim_frame_seq #(
        .DIV_BASE   (8),
        .FRAME_LAST (3),
        .IDX_W      (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int ticks;
    int exp1[5] = '{1, 2, 3, 0, 1};
    int exp6[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Cycles from the current negedge until frame_tick is seen; -1 on timeout
    task automatic wait_tick(output int cyc);
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.frame_tick === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic do_start(input logic d, input logic lp, input logic [1:0] sp);
        @(negedge clk);
        bus.dir     = d;
        bus.loop_en = lp;
        bus.speed   = sp;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef ANIM_PINGPONG_EN
        exp6 = '{1, 2, 3, 2, 1, 0, 1};
`else
        exp6 = '{1, 2, 3, 0, 1, 2, 3};
`endif
        rst = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
        bus.dir = 1'b0; bus.speed = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_idx",  bus.frame_idx, 0);
        check("rst_tick", bus.frame_tick, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;

        // 1: forward loop, speed 0
        do_start(1'b0, 1'b1, 2'd0);
        check("t1_idx0", bus.frame_idx, 0);
        check("t1_busy", bus.busy, 1);
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            check("t1_period", n, 8);
            check("t1_idx", bus.frame_idx, exp1[i]);
        end
        check("t1_done", bus.done, 0);

        // 2: reverse one-shot
        do_start(1'b1, 1'b0, 2'd0);
        check("t2_idx0", bus.frame_idx, 3);
        for (int i = 2; i >= 0; i--) begin
            wait_tick(n);
            check("t2_period", n, 8);
            check("t2_idx", bus.frame_idx, i);
        end
        ticks = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        check("t2_noticks", ticks, 0);
        check("t2_done", bus.done, 1);
        check("t2_busy", bus.busy, 0);
        check("t2_idx_end", bus.frame_idx, 0);

        // 3: pause for 5 cycles at prescaler=4
        do_start(1'b0, 1'b1, 2'd0);
        check("t3_done_clr", bus.done, 0);
        repeat (4) @(negedge clk);
        bus.pause = 1'b1;
        ticks = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        check("t3_pause_busy", bus.busy, 1);
        bus.pause = 1'b0;
        check("t3_pause_ticks", ticks, 0);
        check("t3_pause_idx", bus.frame_idx, 0);
        wait_tick(n);
        check("t3_resume", n, 4);
        check("t3_idx", bus.frame_idx, 1);

        // 4: speed 2, then speed 0->3 at prescaler=5
        do_start(1'b0, 1'b1, 2'd2);
        wait_tick(n);
        check("t4_sp2_period", n, 2);
        wait_tick(n);
        check("t4_sp2_period2", n, 2);
        check("t4_sp2_idx", bus.frame_idx, 2);
        do_start(1'b0, 1'b1, 2'd0);
        check("t4_restart_idx", bus.frame_idx, 0);
        repeat (5) @(negedge clk);
        bus.speed = 2'd3;
        wait_tick(n);
        check("t4_clamp", n, 1);
        check("t4_clamp_idx", bus.frame_idx, 1);

        // restart mid-run in reverse
        do_start(1'b1, 1'b1, 2'd0);
        check("rs_idx", bus.frame_idx, 3);
        wait_tick(n);
        check("rs_period", n, 8);
        check("rs_idx2", bus.frame_idx, 2);

        // 5: async reset mid-run
        do_start(1'b0, 1'b1, 2'd0);
        wait_tick(n);
        wait_tick(n);
        check("t5_pre_idx", bus.frame_idx, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_idx",  bus.frame_idx, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_done", bus.done, 0);
        check("t5_rst_tick", bus.frame_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1'b0, 1'b1, 2'd0);
        check("t5_idx0", bus.frame_idx, 0);
        wait_tick(n);
        check("t5_period", n, 8);
        check("t5_idx1", bus.frame_idx, 1);

        // 6: looped sequence (bounce or wrap depending on build)
        do_start(1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            check("t6_period", n, 8);
            check("t6_idx", bus.frame_idx, exp6[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_anim_frame_seq
`default_nettype wire
